// File: rtl/i2c_arbiter_pkg.sv
// Shared definitions for the two-requester I2C master arbiter:
// FSM state encoding, master status bit positions and command opcodes.
package i2c_arbiter_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    SETTLE,
    WAIT,
    RESP
  } state_t;

  // Bit positions inside the 64-bit master status word
  localparam int STAT_BUSY = 63;
  localparam int STAT_ERR  = 62;
  localparam int STAT_TMO  = 61;

  // Command opcodes understood by the i2cmaster
  localparam logic [1:0] OP_DONE    = 2'b00;
  localparam logic [1:0] OP_RESTART = 2'b01;
  localparam logic [1:0] OP_READ    = 2'b10;
  localparam logic [1:0] OP_WRITE   = 2'b11;

  // Status reported when the watchdog gives up on a transaction
  localparam logic [63:0] TIMEOUT_RSP = (64'd1 << STAT_ERR) | (64'd1 << STAT_TMO);

  // Round-robin pick: 1 selects requester 1, 0 selects requester 0.
  // On contention the requester that was not granted last wins.
  function automatic logic pickGrant(input logic req0, input logic req1,
                                     input logic lastGrant);
    return req1 && (!req0 || !lastGrant);
  endfunction

endpackage

// File: rtl/i2c_prescaler.sv
// Free-running clock-step generator: cstep is high for one CLOCK cycle
// out of every PRESCALE cycles (permanently high when PRESCALE is 1).
module i2c_prescaler #(
  parameter int PRESCALE = 8
) (
  input  logic CLOCK,
  input  logic RESET,
  output logic cstep
);

  localparam logic [7:0] LAST = 8'(PRESCALE - 1);

  logic [7:0] r_count;

  // Wrap the divider counter at PRESCALE-1
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET)               r_count <= 8'd0;
    else if (r_count == LAST) r_count <= 8'd0;
    else                     r_count <= r_count + 8'd1;
  end

  assign cstep = (r_count == LAST);

endmodule

// File: rtl/i2c_arbiter.sv
// Round-robin arbiter letting two requesters share one i2cmaster.
// A granted command is written to the master, the arbiter waits for the
// master's busy flag to clear, captures the status and acks the grantee.
// Optional watchdog: define I2C_ARBITER_TIMEOUT_EN to abort transactions
// that take TIMEOUT cstep pulses in WAIT (pulses m_reset, reports ERR|TMO).
module i2c_arbiter
  import i2c_arbiter_pkg::*;
#(
  parameter int PRESCALE = 8,
  parameter int TIMEOUT  = 4095
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        req0,
  input  logic        req1,
  input  logic [63:0] cmd0,
  input  logic [63:0] cmd1,
  output logic        ack0,
  output logic        ack1,
  output logic [63:0] rsp,
  output logic        busy,
  output logic        m_wrcmd,
  output logic [63:0] m_command,
  input  logic [63:0] m_status,
  output logic        cstep,
  output logic        m_reset
);

  state_t      r_state;
  state_t      w_nextState;
  logic        r_grantee;
  logic [63:0] r_command;
  logic [63:0] r_rsp;
  logic        r_wrcmd;
  logic        r_ack0;
  logic        r_ack1;
  logic        w_cstep;
  logic        w_grant;
  logic        w_anyReq;
  logic        w_wrcmdNext;
  logic        w_ack0Next;
  logic        w_ack1Next;
  logic        w_doneOk;
  logic        w_timeout;
  logic        w_tmoHit;

  i2c_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .CLOCK (CLOCK),
    .RESET (RESET),
    .cstep (w_cstep)
  );

  assign w_anyReq = req0 || req1;
  assign w_grant  = pickGrant(req0, req1, r_grantee);

`ifdef I2C_ARBITER_TIMEOUT_EN
  localparam logic [11:0] TMO_LAST = 12'(TIMEOUT - 1);

  logic [11:0] r_tmoCount;
  logic        r_mreset;

  assign w_tmoHit = (r_state == WAIT) && w_cstep && (r_tmoCount == TMO_LAST);

  // Count cstep pulses spent in WAIT; restart from zero for every transaction
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET)                  r_tmoCount <= 12'd0;
    else if (r_state != WAIT)   r_tmoCount <= 12'd0;
    else if (w_cstep && !w_tmoHit) r_tmoCount <= r_tmoCount + 12'd1;
  end

  // One-cycle synchronous reset request to the master when the watchdog fires
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) r_mreset <= 1'b0;
    else       r_mreset <= w_timeout;
  end

  assign m_reset = r_mreset;
`else
  assign w_tmoHit = 1'b0;
  assign m_reset  = 1'b0;
`endif

  // Next-state and next-strobe decode
  always_comb begin
    w_nextState = r_state;
    w_wrcmdNext = 1'b0;
    w_ack0Next  = 1'b0;
    w_ack1Next  = 1'b0;
    w_doneOk    = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      IDLE:   if (w_anyReq) w_nextState = ISSUE;
      ISSUE:  begin
        w_wrcmdNext = 1'b1;
        w_nextState = SETTLE;
      end
      SETTLE: w_nextState = WAIT;
      WAIT:   begin
        if (!m_status[STAT_BUSY]) begin
          w_doneOk    = 1'b1;
          w_nextState = RESP;
        end else if (w_tmoHit) begin
          w_timeout   = 1'b1;
          w_nextState = RESP;
        end
      end
      RESP:   begin
        w_ack0Next  = !r_grantee;
        w_ack1Next  = r_grantee;
        w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // State register plus registered strobes to the master and requesters
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      r_state <= IDLE;
      r_wrcmd <= 1'b0;
      r_ack0  <= 1'b0;
      r_ack1  <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_wrcmd <= w_wrcmdNext;
      r_ack0  <= w_ack0Next;
      r_ack1  <= w_ack1Next;
    end
  end

  // Grant capture and response capture; r_grantee resets to 1 so req0 wins first
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      r_grantee <= 1'b1;
      r_command <= 64'd0;
      r_rsp     <= 64'd0;
    end else begin
      if (r_state == IDLE && w_anyReq) begin
        r_grantee <= w_grant;
        r_command <= w_grant ? cmd1 : cmd0;
      end
      if (w_doneOk)       r_rsp <= m_status;
      else if (w_timeout) r_rsp <= TIMEOUT_RSP;
    end
  end

  assign busy      = (r_state != IDLE);
  assign m_wrcmd   = r_wrcmd;
  assign m_command = r_command;
  assign ack0      = r_ack0;
  assign ack1      = r_ack1;
  assign rsp       = r_rsp;
  assign cstep     = w_cstep;

endmodule

// File: tb/tb_i2c_arbiter.sv
// Directed testbench for i2c_arbiter with a behavioural i2cmaster model.
// Build with +define+I2C_ARBITER_TIMEOUT_EN to exercise the watchdog.
`timescale 1ns/1ps
module tb_i2c_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req0 = 1'b0;
  logic        req1 = 1'b0;
  logic [63:0] cmd0 = 64'd0;
  logic [63:0] cmd1 = 64'd0;
  logic        ack0, ack1, busy, mWrcmd, cstep, mReset;
  logic [63:0] rsp, mCommand, mStatus;

  logic        fAck0, fAck1, fBusy, fWrcmd, fCstep, fReset;
  logic [63:0] fRsp, fCommand;

  logic        modelBusy = 1'b0;
  int          modelCnt = 0;
  int          modelDelay = 20;
  logic        modelStuck = 1'b0;
  logic [62:0] modelData = 63'd0;

  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  i2c_arbiter #(.PRESCALE(3), .TIMEOUT(10)) dut (
    .CLOCK(clock), .RESET(reset), .req0(req0), .req1(req1),
    .cmd0(cmd0), .cmd1(cmd1), .ack0(ack0), .ack1(ack1), .rsp(rsp),
    .busy(busy), .m_wrcmd(mWrcmd), .m_command(mCommand),
    .m_status(mStatus), .cstep(cstep), .m_reset(mReset)
  );

  i2c_arbiter #(.PRESCALE(1), .TIMEOUT(10)) dutFast (
    .CLOCK(clock), .RESET(reset), .req0(1'b0), .req1(1'b0),
    .cmd0(64'd0), .cmd1(64'd0), .ack0(fAck0), .ack1(fAck1), .rsp(fRsp),
    .busy(fBusy), .m_wrcmd(fWrcmd), .m_command(fCommand),
    .m_status(64'd0), .cstep(fCstep), .m_reset(fReset)
  );

  // Master model: goes busy on a write strobe and clears after modelDelay cycles
  always @(posedge clock) begin
    if (reset || mReset) begin
      modelBusy <= 1'b0;
      modelCnt  <= 0;
    end else if (mWrcmd) begin
      modelBusy <= 1'b1;
      modelCnt  <= modelDelay;
    end else if (modelBusy && !modelStuck) begin
      if (modelCnt <= 1) modelBusy <= 1'b0;
      modelCnt <= modelCnt - 1;
    end
  end

  assign mStatus = {modelBusy, modelData};

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic doReset;
    reset = 1'b1;
    req0 = 1'b0;
    req1 = 1'b0;
    modelStuck = 1'b0;
    step;
    step;
    reset = 1'b0;
  endtask

  task automatic test_reset;
    step;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    vectors++; if (mWrcmd !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_wrcmd: got %b expected 0", mWrcmd); end
    vectors++; if ({ack0, ack1} !== 2'b00) begin miscompares++; $display("[TB] FAIL reset_acks: got %b expected 00", {ack0, ack1}); end
    vectors++; if (rsp !== 64'd0) begin miscompares++; $display("[TB] FAIL reset_rsp: got %h expected 0", rsp); end
    vectors++; if (mCommand !== 64'd0) begin miscompares++; $display("[TB] FAIL reset_cmd: got %h expected 0", mCommand); end
    vectors++; if (mReset !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_mreset: got %b expected 0", mReset); end
  endtask

  task automatic test_single;
    int wrEdge = -1, wrCount = 0, ackEdge = -1, ackCount = 0, ack1Count = 0;
    doReset;
    modelDelay = 20;
    modelData = 63'h0123_4567_89AB_CDEF;
    cmd0 = 64'hC000_0000_0000_0000;
    req0 = 1'b1;
    for (int e = 1; e <= 40; e++) begin
      step;
      if (mWrcmd) begin wrCount++; if (wrEdge < 0) wrEdge = e; end
      if (ack0) begin ackCount++; if (ackEdge < 0) ackEdge = e; req0 = 1'b0; end
      if (ack1) ack1Count++;
      if (e == 10) begin
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL single_busy_mid: got %b expected 1", busy); end
      end
    end
    vectors++; if (wrEdge != 2) begin miscompares++; $display("[TB] FAIL single_wr_edge: got %0d expected 2", wrEdge); end
    vectors++; if (wrCount != 1) begin miscompares++; $display("[TB] FAIL single_wr_count: got %0d expected 1", wrCount); end
    vectors++; if (ackEdge != 25) begin miscompares++; $display("[TB] FAIL single_ack_edge: got %0d expected 25", ackEdge); end
    vectors++; if (ackCount != 1) begin miscompares++; $display("[TB] FAIL single_ack_count: got %0d expected 1", ackCount); end
    vectors++; if (ack1Count != 0) begin miscompares++; $display("[TB] FAIL single_ack1_count: got %0d expected 0", ack1Count); end
    vectors++; if (rsp !== 64'h0123_4567_89AB_CDEF) begin miscompares++; $display("[TB] FAIL single_rsp: got %h expected 0123456789abcdef", rsp); end
    vectors++; if (mCommand !== 64'hC000_0000_0000_0000) begin miscompares++; $display("[TB] FAIL single_cmd: got %h expected c000000000000000", mCommand); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL single_idle: got %b expected 0", busy); end
  endtask

  task automatic test_prescaler;
    doReset;
    for (int e = 1; e <= 12; e++) begin
      step;
      vectors++; if (cstep !== (e % 3 == 2)) begin miscompares++; $display("[TB] FAIL cstep_div3 edge %0d: got %b expected %b", e, cstep, (e % 3 == 2)); end
      vectors++; if (fCstep !== 1'b1) begin miscompares++; $display("[TB] FAIL cstep_div1 edge %0d: got %b expected 1", e, fCstep); end
    end
  endtask

  task automatic test_round_robin;
    logic [63:0] got [3];
    int n = 0;
    doReset;
    modelDelay = 4;
    modelData = 63'h77;
    cmd0 = 64'hAAAA_0000_0000_0001;
    cmd1 = 64'hBBBB_0000_0000_0002;
    for (int i = 0; i < 3; i++) got[i] = 64'd0;
    req0 = 1'b1;
    req1 = 1'b1;
    for (int e = 0; e < 300 && n < 3; e++) begin
      step;
      if (mWrcmd) begin
        got[n] = mCommand;
        n++;
        if (n == 3) begin req0 = 1'b0; req1 = 1'b0; end
      end
    end
    req0 = 1'b0;
    req1 = 1'b0;
    vectors++; if (n != 3) begin miscompares++; $display("[TB] FAIL rr_grant_count: got %0d expected 3", n); end
    vectors++; if (got[0] !== 64'hAAAA_0000_0000_0001) begin miscompares++; $display("[TB] FAIL rr_grant0: got %h expected aaaa000000000001", got[0]); end
    vectors++; if (got[1] !== 64'hBBBB_0000_0000_0002) begin miscompares++; $display("[TB] FAIL rr_grant1: got %h expected bbbb000000000002", got[1]); end
    vectors++; if (got[2] !== 64'hAAAA_0000_0000_0001) begin miscompares++; $display("[TB] FAIL rr_grant2: got %h expected aaaa000000000001", got[2]); end
    for (int e = 0; e < 100 && busy; e++) step;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL rr_idle: got %b expected 0", busy); end
  endtask

  task automatic test_drop_req;
    int a0 = 0, a1 = 0;
    doReset;
    modelDelay = 6;
    cmd1 = 64'h3333_0000_0000_00C3;
    req1 = 1'b1;
    step;
    step;
    vectors++; if (mWrcmd !== 1'b1) begin miscompares++; $display("[TB] FAIL drop_wrcmd: got %b expected 1", mWrcmd); end
    req1 = 1'b0;
    for (int e = 0; e < 40; e++) begin
      step;
      if (ack0) a0++;
      if (ack1) a1++;
    end
    vectors++; if (a1 != 1) begin miscompares++; $display("[TB] FAIL drop_ack1_count: got %0d expected 1", a1); end
    vectors++; if (a0 != 0) begin miscompares++; $display("[TB] FAIL drop_ack0_count: got %0d expected 0", a0); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL drop_idle: got %b expected 0", busy); end
    vectors++; if (mCommand !== 64'h3333_0000_0000_00C3) begin miscompares++; $display("[TB] FAIL drop_cmd: got %h expected 33330000000000c3", mCommand); end
  endtask

  task automatic test_timeout;
    int mrEdge = -1, mrCount = 0, ackEdge = -1, ackCount = 0;
    doReset;
    modelStuck = 1'b1;
    modelDelay = 5;
    cmd0 = 64'h4000_0000_0000_0044;
    req0 = 1'b1;
`ifdef I2C_ARBITER_TIMEOUT_EN
    for (int e = 1; e <= 60; e++) begin
      step;
      if (mReset) begin mrCount++; if (mrEdge < 0) mrEdge = e; end
      if (ack0) begin ackCount++; if (ackEdge < 0) ackEdge = e; req0 = 1'b0; end
    end
    modelStuck = 1'b0;
    vectors++; if (mrEdge != 33) begin miscompares++; $display("[TB] FAIL tmo_mreset_edge: got %0d expected 33", mrEdge); end
    vectors++; if (mrCount != 1) begin miscompares++; $display("[TB] FAIL tmo_mreset_count: got %0d expected 1", mrCount); end
    vectors++; if (ackEdge != 34) begin miscompares++; $display("[TB] FAIL tmo_ack_edge: got %0d expected 34", ackEdge); end
    vectors++; if (ackCount != 1) begin miscompares++; $display("[TB] FAIL tmo_ack_count: got %0d expected 1", ackCount); end
    vectors++; if (rsp[63:61] !== 3'b011) begin miscompares++; $display("[TB] FAIL tmo_rsp_bits: got %b expected 011", rsp[63:61]); end
    vectors++; if (rsp !== 64'h6000_0000_0000_0000) begin miscompares++; $display("[TB] FAIL tmo_rsp: got %h expected 6000000000000000", rsp); end
`else
    for (int e = 1; e <= 100; e++) begin
      step;
      if (mReset) mrCount++;
      if (ack0) ackCount++;
    end
    vectors++; if (mrCount != 0) begin miscompares++; $display("[TB] FAIL notmo_mreset: got %0d expected 0", mrCount); end
    vectors++; if (ackCount != 0) begin miscompares++; $display("[TB] FAIL notmo_ack: got %0d expected 0", ackCount); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL notmo_busy: got %b expected 1", busy); end
    doReset;
`endif
  endtask

  task automatic test_reset_in_wait;
    int a0 = 0;
    doReset;
    modelDelay = 3;
    modelData = 63'h1111;
    cmd0 = 64'h8000_0000_0000_0008;
    req0 = 1'b1;
    for (int e = 0; e < 40 && a0 == 0; e++) begin
      step;
      if (ack0) begin a0++; req0 = 1'b0; end
    end
    req0 = 1'b0;
    vectors++; if (rsp !== 64'h1111) begin miscompares++; $display("[TB] FAIL rw_first_rsp: got %h expected 1111", rsp); end
    step;
    modelDelay = 50;
    req0 = 1'b1;
    for (int e = 0; e < 10; e++) step;
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL rw_busy_before: got %b expected 1", busy); end
    #2;
    reset = 1'b1;
    req0 = 1'b0;
    #1;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL rw_busy: got %b expected 0", busy); end
    vectors++; if (rsp !== 64'd0) begin miscompares++; $display("[TB] FAIL rw_rsp: got %h expected 0", rsp); end
    vectors++; if (mCommand !== 64'd0) begin miscompares++; $display("[TB] FAIL rw_cmd: got %h expected 0", mCommand); end
    vectors++; if ({ack0, ack1, mWrcmd, mReset} !== 4'b0000) begin miscompares++; $display("[TB] FAIL rw_strobes: got %b expected 0000", {ack0, ack1, mWrcmd, mReset}); end
    step;
    reset = 1'b0;
    a0 = 0;
    for (int e = 0; e < 10; e++) begin
      step;
      if (ack0 || ack1) a0++;
    end
    vectors++; if (a0 != 0) begin miscompares++; $display("[TB] FAIL rw_no_ack: got %0d expected 0", a0); end
    modelDelay = 3;
    modelData = 63'h2222;
    cmd0 = 64'h0000_0000_0000_0099;
    req0 = 1'b1;
    for (int e = 0; e < 40; e++) begin
      step;
      if (ack0) begin a0++; req0 = 1'b0; end
    end
    vectors++; if (a0 != 1) begin miscompares++; $display("[TB] FAIL rw_after_ack: got %0d expected 1", a0); end
    vectors++; if (rsp !== 64'h2222) begin miscompares++; $display("[TB] FAIL rw_after_rsp: got %h expected 2222", rsp); end
    vectors++; if (mCommand !== 64'h99) begin miscompares++; $display("[TB] FAIL rw_after_cmd: got %h expected 99", mCommand); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_prescaler;
    test_round_robin;
    test_drop_req;
    test_timeout;
    test_reset_in_wait;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
